binary_to_bcd_display_feeder: RTL and testbench

BINARY_TO_BCD_DISPLAY_FEEDER -- requirements
Module: binary_to_bcd_display_feeder

---
 rtl/binary_to_bcd_display_feeder.sv | 131 +++++++++++++
 tb/tb_binary_to_bcd_display_feeder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_display_feeder.sv
// Serial double-dabble binary-to-BCD converter feeding a segmented display driver.
// Optional macro SATURATE_EN: overflowing values show all nines instead of "E" digits.
module binary_to_bcd_display_feeder #(
   parameter int number_of_nybbles = 4,
   parameter int input_width       = 14
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [input_width-1:0]         in_value,
   input  logic [number_of_nybbles-1:0]   in_dp,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [number_of_nybbles*4-1:0] data,
   output logic [number_of_nybbles-1:0]   dp,
   output logic                           data_valid,
   output logic                           overflow
);

   localparam int bcd_width   = number_of_nybbles * 4;
   localparam int count_width = $clog2(input_width + 1);

   function automatic logic [63:0] max_display_value();
      logic [63:0] v;
      v = 64'd1;
      for (int i = 0; i < number_of_nybbles; i++) v = v * 64'd10;
      return v - 64'd1;
   endfunction

   localparam logic [63:0]            max_value  = max_display_value();
   localparam logic [count_width-1:0] last_count = count_width'(input_width);

   function automatic logic [bcd_width-1:0] add3_digits(input logic [bcd_width-1:0] bcd);
      logic [bcd_width-1:0] r;
      r = bcd;
      for (int i = 0; i < number_of_nybbles; i++) begin
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [bcd_width-1:0] overflow_digits();
`ifdef SATURATE_EN
      return {number_of_nybbles{4'h9}};
`else
      return {number_of_nybbles{4'hE}};
`endif
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                       state;
   state_t                       next_state;
   logic [count_width-1:0]       bit_count;
   logic [bcd_width-1:0]         bcd_reg;
   logic [bcd_width-1:0]         bcd_adj;
   logic [input_width-1:0]       src_reg;
   logic [number_of_nybbles-1:0] dp_cap;
   logic                         ovf_cap;
   logic                         accept;
   logic                         shift_en;
   logic                         finish;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // The SHIFT state spends one extra cycle observing the terminal count before DONE.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      shift_en   = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !reset;
            if (in_valid && !reset) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_count == last_count) next_state = DONE;
            else                         shift_en   = 1'b1;
         end
         DONE: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign bcd_adj = add3_digits(bcd_reg);

   // The carry out of the top digit falls off the left end of the shift.
   always_ff @(posedge clock) begin
      if (reset) begin
         bit_count  <= '0;
         bcd_reg    <= '0;
         src_reg    <= '0;
         dp_cap     <= '0;
         ovf_cap    <= 1'b0;
         data       <= '0;
         dp         <= '0;
         data_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (accept) begin
            src_reg   <= in_value;
            bcd_reg   <= '0;
            bit_count <= '0;
            dp_cap    <= in_dp;
            ovf_cap   <= (64'(in_value) > max_value);
         end
         if (shift_en) begin
            {bcd_reg, src_reg} <= {bcd_adj[bcd_width-2:0], src_reg, 1'b0};
            bit_count          <= bit_count + count_width'(1);
         end
         if (finish) begin
            data       <= ovf_cap ? overflow_digits() : bcd_reg;
            dp         <= dp_cap;
            overflow   <= ovf_cap;
            data_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_binary_to_bcd_display_feeder.sv
// Randomized bench for binary_to_bcd_display_feeder with a decimal-arithmetic reference model.
module tb_binary_to_bcd_display_feeder;

   localparam int N = 4;
   localparam int W = 14;
`ifdef SATURATE_EN
   localparam logic [15:0] FILL = 16'h9999;
`else
   localparam logic [15:0] FILL = 16'hEEEE;
`endif

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [W-1:0]   in_value = '0;
   logic [N-1:0]   in_dp = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N*4-1:0] data;
   logic [N-1:0]   dp;
   logic           data_valid;
   logic           overflow;

   int n_vec  = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   binary_to_bcd_display_feeder #(.number_of_nybbles(N), .input_width(W)) dut (
      .clock(clock), .reset(reset), .in_value(in_value), .in_dp(in_dp),
      .in_valid(in_valid), .in_ready(in_ready), .data(data), .dp(dp),
      .data_valid(data_valid), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] expect_digits(input int v);
      logic [15:0] r;
      int          p;
      r = '0;
      p = 1;
      if (v > 9999) return FILL;
      for (int i = 0; i < N; i++) begin
         r[i*4 +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Reference model: a transfer when idle, the result appears 16 edges later.
   bit          in_flight = 1'b0;
   int          countdown = 0;
   logic [15:0] p_data, m_data;
   logic [3:0]  p_dp, m_dp;
   logic        p_ovf, m_ovf, m_dv;

   always @(posedge clock) begin
      if (reset) begin
         in_flight = 1'b0; countdown = 0;
         m_dv = 1'b0; m_data = '0; m_dp = '0; m_ovf = 1'b0;
      end else begin
         m_dv = 1'b0;
         if (in_flight) begin
            countdown--;
            if (countdown == 0) begin
               m_dv = 1'b1; m_data = p_data; m_dp = p_dp; m_ovf = p_ovf;
               in_flight = 1'b0;
            end
         end else if (in_valid) begin
            p_ovf     = int'(in_value) > 9999;
            p_data    = expect_digits(int'(in_value));
            p_dp      = in_dp;
            in_flight = 1'b1;
            countdown = 16;
         end
      end
   end

   always @(negedge clock) begin
      if (check_en) begin
         check("in_ready",   32'(in_ready),   32'(!reset && !in_flight));
         check("data_valid", 32'(data_valid), 32'(m_dv));
         check("data",       32'(data),       32'(m_data));
         check("dp",         32'(dp),         32'(m_dp));
         check("overflow",   32'(overflow),   32'(m_ovf));
      end
   end

   task automatic wait_ready();
      bit ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("ready_timeout", 32'(0), 32'(1));
   endtask

   task automatic send_and_check(input int v, input logic [3:0] d,
                                 input logic [15:0] exp_data, input logic exp_ovf);
      int lat = -1;
      wait_ready();
      in_valid = 1'b1; in_value = W'(v); in_dp = d;
      @(posedge clock); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock); #1;
         if (data_valid) begin lat = k; break; end
      end
      check("latency",  32'(lat),      32'd16);
      check("lit_data", 32'(data),     32'(exp_data));
      check("lit_dp",   32'(dp),       32'(d));
      check("lit_ovf",  32'(overflow), 32'(exp_ovf));
   endtask

   initial begin
      int dv_count;
      repeat (2) @(posedge clock);
      check_en = 1'b1;
      @(posedge clock); #1;
      check("reset_data", 32'(data), 32'd0);
      check("reset_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      #1 check("ready_after_release", 32'(in_ready), 32'd1);

      send_and_check(1234,  4'b0100, 16'h1234, 1'b0);
      send_and_check(0,     4'b0000, 16'h0000, 1'b0);
      send_and_check(9999,  4'b1001, 16'h9999, 1'b0);
      send_and_check(10000, 4'b0010, FILL,     1'b1);
      send_and_check(16383, 4'b1111, FILL,     1'b1);

      // continuous in_valid with a new value every cycle
      wait_ready();
      for (int k = 0; k < 120; k++) begin
         in_valid = 1'b1;
         in_value = W'($urandom_range(0, 16383));
         in_dp    = N'($urandom);
         @(negedge clock);
      end
      in_valid = 1'b0;

      // reset in the middle of a conversion
      wait_ready();
      in_valid = 1'b1; in_value = W'(4321); in_dp = 4'b0001;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      check("abort_data",  32'(data),     32'd0);
      check("abort_dp",    32'(dp),       32'd0);
      check("abort_ready", 32'(in_ready), 32'd1);
      dv_count = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock); #1;
         if (data_valid) dv_count++;
      end
      check("abort_no_pulse", 32'(dv_count), 32'd0);
      send_and_check(42, 4'b0000, 16'h0042, 1'b0);

      // random traffic with occasional resets
      for (int k = 0; k < 3000; k++) begin
         @(negedge clock);
         reset    = ($urandom_range(0, 199) == 0);
         in_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0:       in_value = W'($urandom_range(9990, 10010));
            1:       in_value = W'($urandom_range(0, 20));
            default: in_value = W'($urandom_range(0, 16383));
         endcase
         in_dp = N'($urandom);
      end
      @(negedge clock);
      reset = 1'b0; in_valid = 1'b0;
      repeat (20) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
